bus_master_port: RTL

- CPU-side initiator for the byte-addressed, waitrequest-stalled memory bus that the test memory responds on.
- Accepts one load/store request at a time from the datapath (byte, half or word; signed or unsigned load).
- Drives word-aligned address, read/write strobes, byteenable and lane-steered writedata; holds them while the responder stalls.
- Returns a lane-extracted, extended load result, or an error for misaligned or timed-out accesses.

---
 rtl/mem_bus_pkg.sv | 25 ++
 rtl/bus_master_port_if.sv | 37 +++
 rtl/bus_lane_steer.sv | 31 +++
 rtl/bus_master_port.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types, constants and alignment helper for the bus master port
package mem_bus_pkg;

    localparam int BUS_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    // Size 3 is not a legal access width, so it never counts as aligned.
    function automatic logic is_aligned(logic [1:0] size, logic [1:0] off);
        return (size == SZ_BYTE) ||
               (size == SZ_HALF && !off[0]) ||
               (size == SZ_WORD && off == 2'b00);
    endfunction

endpackage

// File: rtl/bus_master_port_if.sv
// bus_master_port_if: request/response handshake plus memory bus signals
interface bus_master_port_if
    import mem_bus_pkg::*;
;
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [1:0]                req_size;
    logic                      req_signed;
    logic [31:0]               req_addr;
    logic [31:0]               req_wdata;
    logic                      resp_valid;
    logic [31:0]               resp_rdata;
    logic                      resp_err;
    logic [31:0]               address;
    logic                      read;
    logic                      write;
    logic                      waitrequest;
    logic [31:0]               writedata;
    logic [BUS_WORD_BYTES-1:0] byteenable;
    logic [31:0]               readdata;

    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  waitrequest, readdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output address, read, write, writedata, byteenable
    );

    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output waitrequest, readdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  address, read, write, writedata, byteenable
    );

endinterface

// File: rtl/bus_lane_steer.sv
// bus_lane_steer: little-endian byte-lane steering for stores and extraction/extension for loads
module bus_lane_steer
    import mem_bus_pkg::*;
(
    input  logic [1:0]                size,
    input  logic [1:0]                off,
    input  logic                      sgn,
    input  logic [31:0]               wdata,
    input  logic [31:0]               rdata,
    output logic [BUS_WORD_BYTES-1:0] be,
    output logic [31:0]               wlane,
    output logic [31:0]               rext
);

    logic [31:0] shifted;

    // Lanes are chosen by the byte offset; narrow store data is replicated so every lane carries it.
    always_comb begin
        shifted = rdata >> {off, 3'b000};
        be      = (size == SZ_WORD) ? 4'b1111 :
                  (size == SZ_HALF) ? (off[1] ? 4'b1100 : 4'b0011) :
                  (4'b0001 << off);
        wlane   = (size == SZ_WORD) ? wdata :
                  (size == SZ_HALF) ? {2{wdata[15:0]}} :
                  {4{wdata[7:0]}};
        rext    = (size == SZ_WORD) ? rdata :
                  (size == SZ_HALF) ? {{16{sgn & shifted[15]}}, shifted[15:0]} :
                  {{24{sgn & shifted[7]}}, shifted[7:0]};
    end

endmodule

// File: rtl/bus_master_port.sv
// bus_master_port: single-outstanding load/store initiator on a waitrequest-stalled memory bus
module bus_master_port
    import mem_bus_pkg::*;
#(
    parameter int MIN_WAIT = 1,
    parameter int TIMEOUT  = 64
) (
    input logic               clk,
    input logic               reset,
    bus_master_port_if.master mbus
);

    state_e                    state_q, state_d;
    logic [31:0]               cnt_q, cnt_d;
    logic [31:0]               address_q, address_d;
    logic [31:0]               wdata_q, wdata_d;
    logic [31:0]               rdata_q, rdata_d;
    logic [1:0]                size_q, size_d;
    logic [1:0]                off_q, off_d;
    logic                      sgn_q, sgn_d;
    logic                      read_q, read_d;
    logic                      write_q, write_d;
    logic                      err_q, err_d;
    logic [BUS_WORD_BYTES-1:0] be_q, be_d;

    logic                      accept, aligned, done, tmo, finish, start;
    logic [1:0]                st_size, st_off;
    logic [BUS_WORD_BYTES-1:0] st_be;
    logic [31:0]               st_wlane, st_rext;

    // In IDLE the steering unit sees the incoming request; in BUS it sees the latched one.
    assign st_size = (state_q == IDLE) ? mbus.req_size : size_q;
    assign st_off  = (state_q == IDLE) ? mbus.req_addr[1:0] : off_q;

    bus_lane_steer u_steer (
        .size  (st_size),
        .off   (st_off),
        .sgn   (sgn_q),
        .wdata (mbus.req_wdata),
        .rdata (mbus.readdata),
        .be    (st_be),
        .wlane (st_wlane),
        .rext  (st_rext)
    );

    // Handshake conditions; the first MIN_WAIT bus cycles ignore waitrequest because the responder asserts it late.
    always_comb begin
        aligned = is_aligned(mbus.req_size, mbus.req_addr[1:0]);
        accept  = (state_q == IDLE) && mbus.req_valid;
        start   = accept && aligned;
        done    = (state_q == BUS) && (cnt_q >= 32'(MIN_WAIT)) && !mbus.waitrequest;
        tmo     = (state_q == BUS) && (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1)) && !done;
        finish  = done || tmo;
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: misaligned requests skip the bus and answer directly.
    always_comb begin
        state_d = (state_q == IDLE) ? (mbus.req_valid ? (aligned ? BUS : RESP) : IDLE) :
                  (state_q == BUS)  ? (finish ? RESP : BUS) :
                  IDLE;
    end

    // Datapath next values: bus outputs load at accept, hold through BUS and clear when it ends.
    always_comb begin
        cnt_d     = (state_q == BUS) ? cnt_q + 32'd1 : 32'd0;
        size_d    = accept ? mbus.req_size : size_q;
        off_d     = accept ? mbus.req_addr[1:0] : off_q;
        sgn_d     = accept ? mbus.req_signed : sgn_q;
        address_d = start ? {mbus.req_addr[31:2], 2'b00} : finish ? 32'd0 : address_q;
        read_d    = start ? !mbus.req_write : finish ? 1'b0 : read_q;
        write_d   = start ? mbus.req_write : finish ? 1'b0 : write_q;
        be_d      = start ? st_be : finish ? '0 : be_q;
        wdata_d   = start ? st_wlane : finish ? 32'd0 : wdata_q;
        rdata_d   = accept ? 32'd0 : (done && read_q) ? st_rext : rdata_q;
        err_d     = accept ? !aligned : tmo ? 1'b1 : err_q;
    end

    // Datapath registers; reset drops the strobes immediately, aborting any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= 32'd0;
            size_q    <= 2'd0;
            off_q     <= 2'd0;
            sgn_q     <= 1'b0;
            address_q <= 32'd0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            be_q      <= '0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            size_q    <= size_d;
            off_q     <= off_d;
            sgn_q     <= sgn_d;
            address_q <= address_d;
            read_q    <= read_d;
            write_q   <= write_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Outputs: response fields are only presented during the single RESP cycle.
    always_comb begin
        mbus.req_ready  = (state_q == IDLE);
        mbus.resp_valid = (state_q == RESP);
        mbus.resp_rdata = (state_q == RESP) ? rdata_q : 32'd0;
        mbus.resp_err   = (state_q == RESP) && err_q;
        mbus.address    = address_q;
        mbus.read       = read_q;
        mbus.write      = write_q;
        mbus.byteenable = be_q;
        mbus.writedata  = wdata_q;
    end

endmodule
